// File: rtl/vga_mem_arbiter.sv
// Memory arbiter for a VGA scanline fetcher: display line fetches take strict
// priority over a host port, with in-order read tagging into a double-buffered line buffer.
module vga_mem_arbiter #(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int LINE_WORDS = 40,
  parameter int H          = 480,
  parameter int OSTD       = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            hblank,
  input  logic                            vblank,
  input  logic [AW-1:0]                   fb_base,
  input  logic                            host_valid,
  input  logic                            host_we,
  input  logic [AW-1:0]                   host_addr,
  input  logic [DW-1:0]                   host_wdata,
  output logic                            host_ready,
  output logic                            host_rvalid,
  output logic [DW-1:0]                   host_rdata,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [AW-1:0]                   mem_addr,
  output logic [DW-1:0]                   mem_wdata,
  input  logic                            mem_gnt,
  input  logic                            mem_rvalid,
  input  logic [DW-1:0]                   mem_rdata,
  output logic                            lb_we,
  output logic [$clog2(LINE_WORDS):0]     lb_addr,
  output logic [DW-1:0]                   lb_wdata,
  output logic                            fetch_err,
  output logic                            disp_bank
);

  localparam int WW  = $clog2(LINE_WORDS);
  localparam int LBW = 1 + WW;
  localparam int LW  = $clog2(H + 1);
  localparam int CW  = $clog2(OSTD + 1);
  localparam int PW  = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam int TW  = 1 + LBW;

  typedef enum logic [1:0] {IDLE, FETCH, HOST} state_t;

  state_t          state, state_next;
  logic            hblank_d, vblank_d;
  logic [LW-1:0]   line, line_next;
  logic            trig, trig_pend;
  logic            fill_bank;
  logic [AW-1:0]   fetch_base, fetch_base_next;
  logic [WW:0]     word;
  logic            xfer, fetch_gnt, last_gnt, overrun;

  logic [TW-1:0]   tags [OSTD];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, push, pop;
  logic [TW-1:0]   tag_in, tag_out;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OSTD - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Blank edge detection and line counting; L saturates at H so no fetch follows the last line.
  always_comb begin
    trig      = 1'b0;
    line_next = line;
    if (vblank && !vblank_d) begin
      line_next = '0;
      trig      = 1'b1;
    end else if (hblank && !hblank_d && !vblank) begin
      if (line < LW'(H)) begin
        line_next = line + LW'(1);
        trig      = (line_next < LW'(H));
      end else begin
        line_next = line;
        trig      = 1'b0;
      end
    end else begin
      trig      = 1'b0;
    end
    fetch_base_next = fb_base + (AW'(line_next) * AW'(LINE_WORDS));
  end

  assign fifo_full = (count == CW'(OSTD));
  assign xfer      = mem_req && mem_gnt;
  assign fetch_gnt = (state == FETCH) && xfer;
  assign last_gnt  = fetch_gnt && (word == (WW+1)'(LINE_WORDS - 1));
  assign overrun   = (state == FETCH) && trig && !last_gnt;

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_ready = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = !fifo_full;
        mem_addr = fetch_base + AW'(word);
      end
      HOST: begin
        mem_req    = host_valid && (host_we || !fifo_full);
        mem_we     = host_we;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        host_ready = host_valid && (host_we || !fifo_full) && mem_gnt;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trig) begin
          state_next = FETCH;
        end else if (host_valid) begin
          state_next = HOST;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        if (trig) begin
          state_next = FETCH;
        end else if (last_gnt) begin
          state_next = IDLE;
        end else begin
          state_next = FETCH;
        end
      end
      HOST: begin
        if (xfer) begin
          state_next = (trig || trig_pend) ? FETCH : IDLE;
        end else begin
          state_next = HOST;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A trigger loads the new line's bank/address at once, even if the FSM must first finish a host grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      hblank_d   <= 1'b0;
      vblank_d   <= 1'b0;
      line       <= '0;
      trig_pend  <= 1'b0;
      fill_bank  <= 1'b0;
      disp_bank  <= 1'b0;
      fetch_base <= '0;
      word       <= '0;
      fetch_err  <= 1'b0;
    end else begin
      state    <= state_next;
      hblank_d <= hblank;
      vblank_d <= vblank;
      line     <= line_next;
      if (state == HOST) begin
        if (xfer) begin
          trig_pend <= 1'b0;
        end else if (trig) begin
          trig_pend <= 1'b1;
        end else begin
          trig_pend <= trig_pend;
        end
      end else begin
        trig_pend <= 1'b0;
      end
      if (trig) begin
        fill_bank  <= ~fill_bank;
        disp_bank  <= fill_bank;
        fetch_base <= fetch_base_next;
        word       <= '0;
      end else if (fetch_gnt) begin
        word <= word + (WW+1)'(1);
      end else begin
        word <= word;
      end
      if (overrun) begin
        fetch_err <= 1'b1;
      end else begin
        fetch_err <= fetch_err;
      end
    end
  end

  // Tags are captured at grant time, so words granted before an overrun keep their old bank.
  assign push   = xfer && !mem_we;
  assign pop    = mem_rvalid && (count != '0);
  assign tag_in = (state == HOST) ? {1'b1, {LBW{1'b0}}} : {1'b0, fill_bank, word[WW-1:0]};

  always_ff @(posedge aclk) begin
    if (push) begin
      tags[wr_ptr] <= tag_in;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // An empty FIFO (e.g. just after reset) silently drops any stray return.
  assign tag_out     = tags[rd_ptr];
  assign lb_we       = pop && !tag_out[TW-1];
  assign lb_addr     = tag_out[LBW-1:0];
  assign lb_wdata    = mem_rdata;
  assign host_rvalid = pop && tag_out[TW-1];
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: behavioural memory with controllable grant
// and in-order returns, logs of grants and line-buffer writes, immediate-assert checks.
module tb_vga_mem_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int LBW = 7;

  logic aclk = 1'b0;
  logic aresetn, hblank, vblank;
  logic [AW-1:0] fb_base, host_addr, mem_addr;
  logic host_valid, host_we, host_ready, host_rvalid;
  logic [DW-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata, lb_wdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, lb_we, fetch_err, disp_bank;
  logic [LBW-1:0] lb_addr;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0, rdy_n = 0, last_rdy_cyc = 0, last_lb_cyc = 0, hrv_cyc = 0;
  bit rv_en = 1'b0;
  logic [AW:0] gq[$];
  int gcyc[$];
  logic [DW-1:0] rdq[$];
  logic [LBW+DW-1:0] lbq[$];
  logic [DW-1:0] hq[$];
  logic [DW-1:0] hmem[4];
  bit hval[4];

  vga_mem_arbiter dut (
    .aclk(aclk), .aresetn(aresetn), .hblank(hblank), .vblank(vblank), .fb_base(fb_base),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_err(fetch_err), .disp_bank(disp_bank)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    if (a[AW-1:2] == 16'h0800 && hval[a[1:0]]) return hmem[a[1:0]];
    else return a[15:0] ^ 16'h5A5A;
  endfunction

  // Memory model and transaction logger.
  always @(posedge aclk) begin
    cyc_n <= cyc_n + 1;
    if (mem_req && mem_gnt) begin
      gq.push_back({mem_we, mem_addr});
      gcyc.push_back(cyc_n);
      if (mem_we) begin
        if (mem_addr[AW-1:2] == 16'h0800) begin
          hmem[mem_addr[1:0]] <= mem_wdata;
          hval[mem_addr[1:0]] <= 1'b1;
        end
      end else begin
        rdq.push_back(mdata(mem_addr));
      end
    end
    if (lb_we) begin
      lbq.push_back({lb_addr, lb_wdata});
      last_lb_cyc <= cyc_n;
    end
    if (host_rvalid) begin
      hq.push_back(host_rdata);
      hrv_cyc <= cyc_n;
    end
    if (host_ready) begin
      rdy_n <= rdy_n + 1;
      last_rdy_cyc <= cyc_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
    if (rv_en && rdq.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdq.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  task automatic clear_logs();
    gq.delete(); gcyc.delete(); lbq.delete(); hq.delete();
  endtask

  function automatic int gq_bad(input int off, input logic [AW-1:0] base, input int n);
    int b = 0;
    for (int i = 0; i < n; i++)
      if (off + i >= gq.size() || gq[off+i] !== {1'b0, base + AW'(i)}) b++;
    return b;
  endfunction

  function automatic int lb_bad(input int off, input logic [AW-1:0] base, input logic bank, input int n);
    int b = 0;
    logic [LBW+DW-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = {bank, 6'(i), mdata(base + AW'(i))};
      if (off + i >= lbq.size() || lbq[off+i] !== e) b++;
    end
    return b;
  endfunction

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    int n0 = rdy_n;
    host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    ok = 1'b0;
    repeat (20) begin
      cyc();
      if (rdy_n != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int c1, c2;
    bit ok1, ok2, ok3, ok4;
    aresetn = 1'b0; hblank = 1'b0; vblank = 1'b0; fb_base = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) cyc();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_host_ready", host_ready, 1'b0);
    chk("rst_host_rvalid", host_rvalid, 1'b0);
    chk("rst_lb_we", lb_we, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_disp_bank", disp_bank, 1'b0);
    aresetn = 1'b1;
    cyc();

    // Frame start: line 0 from 0x100 into fill bank 1; display shows previous fill bank 0.
    fb_base = 18'h100; mem_gnt = 1'b1; rv_en = 1'b1; vblank = 1'b1;
    repeat (50) cyc();
    chk("l0_grants", gq.size(), 40);
    chk("l0_addr_bad", gq_bad(0, 18'h100, 40), 0);
    chk("l0_lb_count", lbq.size(), 40);
    chk("l0_lb_bad", lb_bad(0, 18'h100, 1'b1, 40), 0);
    chk("l0_disp_bank", disp_bank, 1'b0);
    chk("l0_fetch_err", fetch_err, 1'b0);
    chk("l0_idle_req", mem_req, 1'b0);

    // Line 1 (0x128, bank 0) with a host read of 0x3000 pending behind it.
    vblank = 1'b0; cyc(); clear_logs();
    hblank = 1'b1; cyc();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 18'h3000;
    repeat (100) begin cyc(); if (rdy_n > 0) break; end
    host_valid = 1'b0;
    repeat (5) cyc();
    chk("l1_grants", gq.size(), 41);
    chk("l1_addr_bad", gq_bad(0, 18'h128, 40), 0);
    chk("l1_host_grant", gq[40], {1'b0, 18'h3000});
    chk("l1_host_ready_gap", last_rdy_cyc - gcyc[39], 2);
    chk("l1_lb_bad", lb_bad(0, 18'h128, 1'b0, 40), 0);
    chk("l1_host_rcount", hq.size(), 1);
    chk("l1_host_rdata", hq[0], 16'h6A5A);
    chk("l1_host_rvalid_order", hrv_cyc - last_lb_cyc, 2);
    chk("l1_disp_bank", disp_bank, 1'b1);

    // Line 2 (0x150, bank 1) with returns withheld: only OSTD=4 reads go out.
    hblank = 1'b0; cyc(); clear_logs();
    rv_en = 1'b0; hblank = 1'b1;
    repeat (11) cyc();
    chk("ostd_grants", gq.size(), 4);
    chk("ostd_req_low", mem_req, 1'b0);
    rv_en = 1'b1;
    repeat (60) cyc();
    chk("l2_grants", gq.size(), 40);
    chk("l2_addr_bad", gq_bad(0, 18'h150, 40), 0);
    chk("l2_lb_bad", lb_bad(0, 18'h150, 1'b1, 40), 0);

    // Line 3 (0x178, bank 0) overrun after 20 words by line 4 (0x1A0, bank 1).
    hblank = 1'b0; cyc(); clear_logs();
    hblank = 1'b1; cyc();
    hblank = 1'b0;
    repeat (60) begin cyc(); if (gq.size() >= 20) break; end
    chk("ovr_pre_grants", gq.size(), 20);
    mem_gnt = 1'b0; hblank = 1'b1; cyc();
    mem_gnt = 1'b1;
    chk("ovr_fetch_err", fetch_err, 1'b1);
    chk("ovr_disp_bank", disp_bank, 1'b0);
    repeat (50) cyc();
    chk("ovr_grants", gq.size(), 60);
    chk("ovr_old_addr_bad", gq_bad(0, 18'h178, 20), 0);
    chk("ovr_new_addr_bad", gq_bad(20, 18'h1A0, 40), 0);
    chk("ovr_old_lb_bad", lb_bad(0, 18'h178, 1'b0, 20), 0);
    chk("ovr_new_lb_bad", lb_bad(20, 18'h1A0, 1'b1, 40), 0);

    // Step through lines 5..479 with grants blocked, then let line 479 complete.
    mem_gnt = 1'b0;
    for (int k = 0; k < 475; k++) begin
      hblank = 1'b0; cyc();
      hblank = 1'b1; cyc();
    end
    hblank = 1'b0; clear_logs();
    mem_gnt = 1'b1;
    repeat (50) cyc();
    chk("l479_grants", gq.size(), 40);
    chk("l479_addr_bad", gq_bad(0, 18'h4BD8, 40), 0);
    chk("l479_lb_bad", lb_bad(0, 18'h4BD8, 1'b0, 40), 0);
    chk("l479_disp_bank", disp_bank, 1'b1);
    clear_logs();
    hblank = 1'b1;
    repeat (5) cyc();
    chk("l480_no_fetch", gq.size(), 0);
    chk("l480_req_low", mem_req, 1'b0);
    chk("l480_disp_bank", disp_bank, 1'b1);

    // Host requests back-to-back.
    host_op(1'b1, 18'h2000, 16'hBEEF, ok1); c1 = last_rdy_cyc;
    host_op(1'b1, 18'h2001, 16'hCAFE, ok2); c2 = last_rdy_cyc;
    host_op(1'b0, 18'h2000, 16'h0000, ok3);
    host_op(1'b0, 18'h2001, 16'h0000, ok4);
    host_valid = 1'b0;
    repeat (4) cyc();
    chk("host_all_accepted", {ok1, ok2, ok3, ok4}, 4'b1111);
    chk("host_b2b_gap", c2 - c1, 2);
    chk("host_rcount", hq.size(), 2);
    chk("host_rdata0", hq[0], 16'hBEEF);
    chk("host_rdata1", hq[1], 16'hCAFE);

    // Host write accepted while the tag FIFO is full of host reads; a further read waits.
    clear_logs(); rv_en = 1'b0;
    for (int k = 0; k < 4; k++) host_op(1'b0, 18'h2002, 16'h0000, ok1);
    host_op(1'b1, 18'h2003, 16'h1234, ok2);
    chk("full_write_accepted", ok2, 1'b1);
    host_op(1'b0, 18'h2003, 16'h0000, ok3);
    chk("full_read_blocked", ok3, 1'b0);
    rv_en = 1'b1;
    c1 = rdy_n;
    repeat (20) begin cyc(); if (rdy_n != c1) break; end
    host_valid = 1'b0;
    chk("full_read_released", rdy_n - c1, 1);
    repeat (8) cyc();
    chk("full_rcount", hq.size(), 5);
    chk("full_rdata_first", hq[0], 16'h7A58);
    chk("full_rdata_after_write", hq[4], 16'h1234);

    // Reset mid-fetch with 3 reads outstanding; their late returns must be dropped.
    clear_logs(); rv_en = 1'b0; vblank = 1'b1;
    repeat (20) begin cyc(); if (gq.size() >= 3) break; end
    mem_gnt = 1'b0;
    chk("rst_mid_outstanding", gq.size(), 3);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_host_ready", host_ready, 1'b0);
    chk("rst_mid_host_rvalid", host_rvalid, 1'b0);
    chk("rst_mid_lb_we", lb_we, 1'b0);
    chk("rst_mid_fetch_err", fetch_err, 1'b0);
    chk("rst_mid_disp_bank", disp_bank, 1'b0);
    vblank = 1'b0; hblank = 1'b0;
    repeat (2) cyc();
    aresetn = 1'b1; rv_en = 1'b1;
    repeat (6) cyc();
    chk("late_returns_offered", rdq.size(), 0);
    chk("late_lb_writes", lbq.size(), 0);
    chk("late_host_rvalid", hq.size(), 0);
    chk("post_rst_req", mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
